// File: rtl/rng_req_arbiter.sv
// Round-robin arbiter sharing one RNG core among NREQ requesters: sequences reseeding,
// selects the core mode per winner and returns a sampled byte with a grant pulse.
// Optional grant counter output enabled by defining RNG_ARB_STATS_EN.
module rng_req_arbiter #(
   parameter int          NREQ         = 4,
   parameter int          SEED_CYCLES  = 2,
   parameter int          GAP_CYCLES   = 1,
   parameter logic [3:0]  DEFAULT_SEED = 4'h1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NREQ-1:0]     req,
   input  logic [2*NREQ-1:0]   req_mode,
   input  logic                reseed,
   input  logic [3:0]          seed_in,
   output logic                rng_reset,
   output logic [3:0]          rng_seed,
   output logic [1:0]          rng_mode,
   input  logic [7:0]          rng_data,
   output logic [NREQ-1:0]     gnt,
   output logic [7:0]          data_out,
   output logic                data_valid,
   output logic                busy
`ifdef RNG_ARB_STATS_EN
   ,
   output logic [15:0]         grant_count
`endif
);

   localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CMAX  = (SEED_CYCLES > GAP_CYCLES) ? SEED_CYCLES : GAP_CYCLES;
   localparam int CNT_W = $clog2(CMAX + 1);

   typedef enum logic [2:0] {
      S_SEED,
      S_IDLE,
      S_SETTLE,
      S_DELIVER,
      S_GAP
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [IW-1:0]      rr;
   logic [IW-1:0]      win;
   logic [IW-1:0]      pick;
   logic [IW-1:0]      cand;
   logic               found;
   logic               pending;
   logic [1:0]         modes [NREQ];
   logic [NREQ-1:0]    onehot_lsb;

   assign onehot_lsb = {{(NREQ-1){1'b0}}, 1'b1};

   always_comb begin
      for (int i = 0; i < NREQ; i++) modes[i] = req_mode[2*i +: 2];
   end

   // Round-robin search starts just after the last winner and wraps modulo NREQ.
   always_comb begin
      pick  = rr;
      cand  = '0;
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IW'((int'(rr) + k) % NREQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_SEED;
         cnt        <= '0;
         rng_reset  <= 1'b1;
         rng_seed   <= DEFAULT_SEED;
         rng_mode   <= 2'b00;
         gnt        <= '0;
         data_out   <= 8'h00;
         data_valid <= 1'b0;
         busy       <= 1'b1;
         rr         <= IW'(NREQ - 1);
         win        <= '0;
         pending    <= 1'b0;
      end else begin
         // A reseed seen outside IDLE is remembered and served at the next IDLE.
         if (state != S_IDLE && reseed) pending <= 1'b1;
         case (state)
            S_SEED: begin
               if (cnt == CNT_W'(SEED_CYCLES - 1)) begin
                  cnt       <= '0;
                  rng_reset <= 1'b0;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_IDLE: begin
               if (reseed || pending) begin
                  rng_seed  <= (seed_in == 4'h0) ? DEFAULT_SEED : seed_in;
                  pending   <= 1'b0;
                  rng_reset <= 1'b1;
                  cnt       <= '0;
                  busy      <= 1'b1;
                  state     <= S_SEED;
               end else if (|req) begin
                  rng_mode <= modes[pick];
                  win      <= pick;
                  busy     <= 1'b1;
                  state    <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               data_out   <= rng_data;
               gnt        <= onehot_lsb << win;
               data_valid <= 1'b1;
               rr         <= win;
               state      <= S_DELIVER;
            end
            S_DELIVER: begin
               gnt        <= '0;
               data_valid <= 1'b0;
               if (GAP_CYCLES == 0) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  cnt   <= '0;
                  state <= S_GAP;
               end
            end
            S_GAP: begin
               if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                  cnt   <= '0;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state      <= S_SEED;
               cnt        <= '0;
               rng_reset  <= 1'b1;
               gnt        <= '0;
               data_valid <= 1'b0;
               busy       <= 1'b1;
            end
         endcase
      end
   end

`ifdef RNG_ARB_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant_count <= '0;
      end else if (state == S_IDLE && (reseed || pending)) begin
         grant_count <= '0;
      end else if (state == S_SETTLE && grant_count != 16'hFFFF) begin
         grant_count <= grant_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_rng_req_arbiter.sv
// Self-checking bench for rng_req_arbiter: vector table, corner sequences and a
// randomized run against a timeline-based reference model.
module tb_rng_req_arbiter;

   localparam int N    = 4;
   localparam int SEED = 2;
   localparam int GAP  = 1;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] req;
   logic [2*N-1:0] req_mode;
   logic         reseed;
   logic [3:0]   seed_in;
   logic         rng_reset;
   logic [3:0]   rng_seed;
   logic [1:0]   rng_mode;
   logic [7:0]   rng_data;
   logic [N-1:0] gnt;
   logic [7:0]   data_out;
   logic         data_valid;
   logic         busy;
`ifdef RNG_ARB_STATS_EN
   logic [15:0]  grant_count;
`endif

   rng_req_arbiter #(
      .NREQ(N), .SEED_CYCLES(SEED), .GAP_CYCLES(GAP), .DEFAULT_SEED(4'h1)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .req_mode(req_mode),
      .reseed(reseed), .seed_in(seed_in), .rng_reset(rng_reset),
      .rng_seed(rng_seed), .rng_mode(rng_mode), .rng_data(rng_data),
      .gnt(gnt), .data_out(data_out), .data_valid(data_valid), .busy(busy)
`ifdef RNG_ARB_STATS_EN
      , .grant_count(grant_count)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   typedef struct {
      logic [3:0] rq;
      logic [7:0] md;
      logic [7:0] dat;
      logic [3:0] egnt;
      logic [1:0] emode;
   } vec_t;
   vec_t vt [7];

   // reference model state: edge numbers at which things happen
   int         m_next, m_seed_end, m_gedge, m_last, m_win;
   bit         m_pend;
   logic [3:0] m_seed;
   logic [1:0] m_mode;
   logic [7:0] m_data;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy !== 1'b0 && n < budget) begin
         tick();
         n++;
      end
      if (busy !== 1'b0) chk("idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic model_reset();
      m_seed_end = SEED;
      m_next     = SEED + 1;
      m_gedge    = -10;
      m_last     = N - 1;
      m_win      = 0;
      m_pend     = 1'b0;
      m_seed     = 4'h1;
      m_mode     = 2'b00;
      m_data     = 8'h00;
   endtask

   task automatic model_step(input int e);
      int idx;
      logic [7:0] rm;
      if (e == m_gedge) m_data = rng_data;
      if (e < m_next) begin
         if (reseed) m_pend = 1'b1;
      end else if (reseed || m_pend) begin
         m_seed     = (seed_in == 4'h0) ? 4'h1 : seed_in;
         m_pend     = 1'b0;
         m_seed_end = e + SEED;
         m_next     = e + SEED + 1;
      end else if (req != '0) begin
         idx = -1;
         for (int k = 1; k <= N; k++)
            if (idx < 0 && req[(m_last + k) % N]) idx = (m_last + k) % N;
         rm      = req_mode;
         m_mode  = 2'((rm >> (2 * idx)) & 8'h3);
         m_win   = idx;
         m_last  = idx;
         m_gedge = e + 1;
         m_next  = e + 3 + GAP;
      end else begin
         m_next = e + 1;
      end
   endtask

   initial begin
      int cyc, cnt, e;
      int gidx [5];
      int gcyc [5];
      logic [20:0] act_v, exp_v;
      logic [3:0]  eg;

      vt[0] = '{4'b0100, 8'h20, 8'h5A, 4'b0100, 2'b10};
      vt[1] = '{4'b1111, 8'hE4, 8'h3C, 4'b1000, 2'b11};
      vt[2] = '{4'b1111, 8'hE4, 8'hC3, 4'b0001, 2'b00};
      vt[3] = '{4'b0101, 8'h1B, 8'h81, 4'b0100, 2'b01};
      vt[4] = '{4'b0011, 8'h1B, 8'h7E, 4'b0001, 2'b11};
      vt[5] = '{4'b0001, 8'h1B, 8'hFF, 4'b0001, 2'b11};
      vt[6] = '{4'b1000, 8'h1B, 8'h00, 4'b1000, 2'b00};

      reset = 1'b1; req = '0; req_mode = '0; reseed = 1'b0; seed_in = 4'h0; rng_data = 8'h00;

      // reset held 3 cycles
      repeat (3) tick();
      chk("rst_rng_reset", 32'(rng_reset), 32'd1);
      chk("rst_seed", 32'(rng_seed), 32'h1);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_dv", 32'(data_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      reset = 1'b0;
      tick();
      chk("seed_hold1", 32'(rng_reset), 32'd1);
      tick();
      chk("seed_release", 32'(rng_reset), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);

      // table-driven single grants
      for (int i = 0; i < 7; i++) begin
         wait_idle(20);
         req = vt[i].rq; req_mode = vt[i].md; rng_data = vt[i].dat;
         tick();
         chk($sformatf("v%0d_mode", i), 32'(rng_mode), 32'(vt[i].emode));
         chk($sformatf("v%0d_nogntyet", i), 32'(gnt), 32'd0);
         req = '0; req_mode = ~vt[i].md;
         tick();
         chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vt[i].egnt));
         chk($sformatf("v%0d_dv", i), 32'(data_valid), 32'd1);
         chk($sformatf("v%0d_data", i), 32'(data_out), 32'(vt[i].dat));
         chk($sformatf("v%0d_mode_hold", i), 32'(rng_mode), 32'(vt[i].emode));
         rng_data = ~vt[i].dat;
         tick();
         chk($sformatf("v%0d_gnt_off", i), 32'(gnt), 32'd0);
         chk($sformatf("v%0d_dv_off", i), 32'(data_valid), 32'd0);
         chk($sformatf("v%0d_data_hold", i), 32'(data_out), 32'(vt[i].dat));
      end

      // reseed arriving during SETTLE
      wait_idle(20);
      req = 4'b0010; req_mode = 8'h0C; rng_data = 8'h99;
      tick();
      reseed = 1'b1; seed_in = 4'hA;
      tick();
      chk("rs_gnt", 32'(gnt), 32'b0010);
      chk("rs_data", 32'(data_out), 32'h99);
      reseed = 1'b0; req = '0;
      tick();
      chk("rs_gnt_off", 32'(gnt), 32'd0);
      tick();
      chk("rs_not_yet", 32'(rng_reset), 32'd0);
      tick();
      chk("rs_reset1", 32'(rng_reset), 32'd1);
      chk("rs_seed", 32'(rng_seed), 32'hA);
`ifdef RNG_ARB_STATS_EN
      chk("rs_count", 32'(grant_count), 32'd0);
`endif
      tick();
      chk("rs_reset2", 32'(rng_reset), 32'd1);
      tick();
      chk("rs_reset_end", 32'(rng_reset), 32'd0);
      chk("rs_idle", 32'(busy), 32'd0);
      req = 4'b0010; rng_data = 8'h42;
      tick();
      req = '0;
      tick();
      chk("rs_resume_gnt", 32'(gnt), 32'b0010);
      chk("rs_resume_data", 32'(data_out), 32'h42);

      // zero seed while idle
      wait_idle(20);
      reseed = 1'b1; seed_in = 4'h0;
      tick();
      reseed = 1'b0;
      chk("z_reset1", 32'(rng_reset), 32'd1);
      chk("z_seed", 32'(rng_seed), 32'h1);
      tick();
      chk("z_reset2", 32'(rng_reset), 32'd1);
      tick();
      chk("z_reset_end", 32'(rng_reset), 32'd0);

      // reset during DELIVER
      wait_idle(20);
      req = 4'b0100; rng_data = 8'hB7;
      tick();
      tick();
      chk("rd_gnt", 32'(gnt), 32'b0100);
      #2 reset = 1'b1;
      #1;
      chk("rd_gnt_clr", 32'(gnt), 32'd0);
      chk("rd_dv_clr", 32'(data_valid), 32'd0);
      chk("rd_data_clr", 32'(data_out), 32'd0);
      req = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rd_no_gnt", 32'(gnt | N'(data_valid)), 32'd0);
      end
      reset = 1'b0;

      // all requesters held: rotation 0,1,2,3,0 with fixed spacing
      req = 4'b1111; req_mode = 8'hE4;
      cnt = 0; cyc = 0;
      while (cnt < 5 && cyc < 60) begin
         tick();
         cyc++;
         if (gnt != '0) begin
            chk("rot_onehot", 32'($countones(gnt)), 32'd1);
            for (int b = 0; b < N; b++) if (gnt[b]) gidx[cnt] = b;
            gcyc[cnt] = cyc;
            cnt++;
         end
      end
      chk("rot_count", 32'(cnt), 32'd5);
      for (int j = 0; j < cnt; j++) begin
         chk($sformatf("rot_idx%0d", j), 32'(gidx[j]), 32'(j % N));
         if (j > 0) chk($sformatf("rot_gap%0d", j), 32'(gcyc[j] - gcyc[j-1]), 32'(3 + GAP));
      end
      req = '0;

      // randomized run against the reference model
      tick();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      model_reset();
      e = 0;
      for (int i = 0; i < 1500; i++) begin
         req      = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
         req_mode = 8'($urandom);
         rng_data = 8'($urandom);
         reseed   = ($urandom_range(0, 24) == 0);
         seed_in  = 4'($urandom);
         tick();
         e++;
         model_step(e);
         eg    = (e == m_gedge) ? (4'b0001 << m_win) : 4'b0000;
         exp_v = {(e < m_seed_end), m_seed, m_mode, eg, (e == m_gedge), m_data, (e + 1 < m_next)};
         act_v = {rng_reset, rng_seed, rng_mode, gnt, data_valid, data_out, busy};
         chk($sformatf("rand_c%0d", e), 32'(act_v), 32'(exp_v));
      end
      reseed = 1'b0; req = '0;

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
